// File: rtl/viterbi_chan_pkg.sv
// Shared types and constants for the error-injecting channel between the
// convolutional encoder and the Viterbi decoder.
package viterbi_chan_pkg;

    localparam int          CT_W      = 16;
    // Galois feedback for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        MODE_CLEAN    = 2'd0,
        MODE_RANDOM   = 2'd1,
        MODE_BURST    = 2'd2,
        MODE_PERIODIC = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/chan_lfsr16.sv
// 16-bit Galois LFSR that steps once per accepted symbol; reloads seed on reset.
module chan_lfsr16
    import viterbi_chan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= seed;
        end else if (adv) begin
            q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
        end
    end

endmodule

// File: rtl/viterbi_chan_err_inj.sv
// Registered encoder->decoder channel that corrupts symbols in clean, random,
// burst or periodic modes and keeps saturating injection statistics.
module viterbi_chan_err_inj
    import viterbi_chan_pkg::*;
#(
    parameter int          W         = 2,
    parameter int          N         = 4,
    parameter int          BURST_LEN = 2,
    parameter int          WINDOW    = 256,
    parameter logic [15:0] SEED      = 16'hACE1
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [1:0]      mode_i,
    input  logic            valid_i,
    input  logic [W-1:0]    sym_i,
    output logic            valid_o,
    output logic [W-1:0]    sym_o,
    output logic            err_o,
    output logic [CT_W-1:0] inj_ct_o,
    output logic [CT_W-1:0] bad_bit_ct_o,
    output logic [CT_W-1:0] word_ct_o,
    output state_e          state_o,
    output logic [15:0]     lfsr_o
);

    // valid_i qualifies sym_i every cycle; there is no ready, the channel never stalls.
    localparam logic [CT_W:0] WIN_L = (CT_W+1)'(WINDOW);
    localparam logic [7:0]    BLEN  = 8'(BURST_LEN);

    mode_e        mode;
    state_e       state, state_nx;
    logic [7:0]   burst_ct, burst_ct_nx;
    logic [15:0]  lfsr;
    logic [W-1:0] cand, mask;
    logic         win_ok, inject_ok, trig, abort;
    logic [CT_W:0] pop, bad_sum;

    chan_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (valid_i),
        .seed (SEED),
        .q    (lfsr)
    );

    assign mode      = mode_e'(mode_i);
    // An all-zero candidate would make an injection event invisible, so force bit 0.
    assign cand      = (lfsr[8 +: W] == '0) ? W'(1) : lfsr[8 +: W];
    assign win_ok    = (WINDOW == 0) || ({1'b0, word_ct_o} < WIN_L);
    assign inject_ok = en_i && valid_i && win_ok;
    assign trig      = (lfsr[N-1:0] == {N{1'b1}});
    assign abort     = !en_i || (mode != MODE_BURST) || !win_ok;

    always_comb begin
        mask        = '0;
        state_nx    = state;
        burst_ct_nx = burst_ct;
        case (state)
            ST_IDLE: begin
                case (mode)
                    MODE_RANDOM:   if (inject_ok && trig) mask = cand;
                    MODE_PERIODIC: if (inject_ok && word_ct_o[N-1:0] == {N{1'b1}}) mask = '1;
                    MODE_BURST: begin
                        if (inject_ok && trig) begin
                            mask        = cand;
                            burst_ct_nx = 8'd1;
                            if (BURST_LEN > 1) state_nx = ST_BURST;
                        end
                    end
                    default: ;
                endcase
            end
            ST_BURST: begin
                // An aborted burst lets the current symbol through untouched.
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (valid_i) begin
                    mask        = cand;
                    burst_ct_nx = burst_ct + 8'd1;
                    if (burst_ct_nx == BLEN) state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign pop     = (CT_W+1)'($countones(mask));
    assign bad_sum = {1'b0, bad_bit_ct_o} + pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            burst_ct     <= '0;
            valid_o      <= 1'b0;
            sym_o        <= '0;
            err_o        <= 1'b0;
            inj_ct_o     <= '0;
            bad_bit_ct_o <= '0;
            word_ct_o    <= '0;
        end else begin
            state    <= state_nx;
            burst_ct <= burst_ct_nx;
            valid_o  <= valid_i;
            sym_o    <= sym_i ^ mask;
            err_o    <= (mask != '0);
            if (valid_i) begin
                if (word_ct_o != '1) word_ct_o <= word_ct_o + 1'b1;
                if ((mask != '0) && (inj_ct_o != '1)) inj_ct_o <= inj_ct_o + 1'b1;
                bad_bit_ct_o <= bad_sum[CT_W] ? '1 : bad_sum[CT_W-1:0];
            end
        end
    end

    assign state_o = state;
    assign lfsr_o  = lfsr;

endmodule

// File: tb/tb_viterbi_chan_err_inj.sv
// Directed bench for viterbi_chan_err_inj: vector table for the periodic pattern,
// hand sequences for bursts, aborts and reset, plus a spec-level reference model.
module tb_viterbi_chan_err_inj;
    import viterbi_chan_pkg::*;

    localparam int          W    = 2;
    localparam int          N    = 4;
    localparam int          BLEN = 3;
    localparam int          WIN  = 256;
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en_i = 1'b0;
    logic [1:0]   mode_i = 2'd0;
    logic         valid_i = 1'b0;
    logic [W-1:0] sym_i = '0;
    logic         valid_o, err_o;
    logic [W-1:0] sym_o;
    logic [15:0]  inj_ct_o, bad_bit_ct_o, word_ct_o, lfsr_o;
    state_e       state_o;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [15:0]  m_lfsr, m_word, m_inj, m_bad;
    logic         m_burst;
    int           m_bct;
    logic [W-1:0] m_mask;
    logic         exp_valid, exp_err;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         valid;
        logic [W-1:0] sym;
        logic [W-1:0] exp_sym;
        logic         exp_err;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    viterbi_chan_err_inj #(
        .W(W), .N(N), .BURST_LEN(BLEN), .WINDOW(WIN), .SEED(SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .mode_i       (mode_i),
        .valid_i      (valid_i),
        .sym_i        (sym_i),
        .valid_o      (valid_o),
        .sym_o        (sym_o),
        .err_o        (err_o),
        .inj_ct_o     (inj_ct_o),
        .bad_bit_ct_o (bad_bit_ct_o),
        .word_ct_o    (word_ct_o),
        .state_o      (state_o),
        .lfsr_o       (lfsr_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic model_reset();
        m_lfsr  = SEED;
        m_word  = '0;
        m_inj   = '0;
        m_bad   = '0;
        m_burst = 1'b0;
        m_bct   = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic e, input logic [1:0] md, input logic v, input logic [W-1:0] s);
        logic [W-1:0] cand;
        logic [15:0]  pc;
        logic         win, ok, trig;
        cand = m_lfsr[9:8];
        if (cand == '0) cand = 2'b01;
        win  = (int'(m_word) < WIN);
        ok   = e && v && win;
        trig = (m_lfsr[3:0] == 4'hF);
        m_mask = '0;
        if (m_burst) begin
            if (!e || md != 2'd2 || !win) m_burst = 1'b0;
            else if (v) begin
                m_mask = cand;
                m_bct++;
                if (m_bct == BLEN) m_burst = 1'b0;
            end
        end else begin
            if (md == 2'd1 && ok && trig) m_mask = cand;
            if (md == 2'd3 && ok && m_word[3:0] == 4'hF) m_mask = 2'b11;
            if (md == 2'd2 && ok && trig) begin
                m_mask  = cand;
                m_bct   = 1;
                m_burst = 1'b1;
            end
        end
        exp_q.push_back(s ^ m_mask);
        exp_valid = v;
        exp_err   = (m_mask != '0);
        if (v) begin
            pc = 16'(m_mask[0]) + 16'(m_mask[1]);
            if (m_word != 16'hFFFF) m_word++;
            if (m_mask != '0 && m_inj != 16'hFFFF) m_inj++;
            m_bad  = (m_bad > 16'hFFFF - pc) ? 16'hFFFF : m_bad + pc;
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    // Drive one cycle from a negedge, let the DUT clock it, compare at the next negedge.
    task automatic step(input logic e, input logic [1:0] md, input logic v, input logic [W-1:0] s);
        logic [W-1:0] es;
        en_i = e; mode_i = md; valid_i = v; sym_i = s;
        model_step(e, md, v, s);
        @(posedge clk);
        @(negedge clk);
        es = exp_q.pop_front();
        check("valid_o", 32'(valid_o), 32'(exp_valid));
        check("sym_o", 32'(sym_o), 32'(es));
        check("err_o", 32'(err_o), 32'(exp_err));
        check("inj_ct", 32'(inj_ct_o), 32'(m_inj));
        check("bad_bit_ct", 32'(bad_bit_ct_o), 32'(m_bad));
        check("word_ct", 32'(word_ct_o), 32'(m_word));
        check("state", 32'(state_o), 32'(m_burst));
        check("lfsr", 32'(lfsr_o), 32'(m_lfsr));
    endtask

    task automatic do_reset();
        rst = 1'b0; en_i = 1'b0; valid_i = 1'b0; mode_i = 2'd0; sym_i = '0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b1;
    endtask

    task automatic find_burst(output int n);
        n = 0;
        while (!m_burst && n < 250) begin
            step(1'b1, 2'd2, 1'b1, W'($urandom_range(0, 3)));
            n++;
        end
        check("burst_found", 32'(n < 250), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, i, n_first, n_again;
        logic [W-1:0] s;
        logic [15:0]  bad0;

        // periodic vector table: every 9th cycle is a gap, every 16th valid is flipped
        k = 0; i = 0;
        while (k < 64) begin
            vec_t r;
            r.valid   = (i % 9 != 4);
            r.sym     = W'($urandom_range(0, 3));
            r.exp_err = r.valid && (k % 16 == 15);
            r.exp_sym = r.exp_err ? ~r.sym : r.sym;
            if (r.valid) k++;
            tbl.push_back(r);
            i++;
        end

        // reset values
        model_reset();
        @(negedge clk);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_sym_o", 32'(sym_o), 32'd0);
        check("rst_err_o", 32'(err_o), 32'd0);
        check("rst_inj", 32'(inj_ct_o), 32'd0);
        check("rst_bad", 32'(bad_bit_ct_o), 32'd0);
        check("rst_word", 32'(word_ct_o), 32'd0);
        check("rst_state", 32'(state_o), 32'(ST_IDLE));
        check("rst_lfsr", 32'(lfsr_o), 32'hACE1);
        do_reset();

        // clean pass-through
        for (int j = 0; j < 300; j++) begin
            s = W'($urandom_range(0, 3));
            step(1'b1, 2'd0, 1'b1, s);
            check("clean_sym", 32'(sym_o), 32'(s));
        end
        check("clean_inj", 32'(inj_ct_o), 32'd0);
        check("clean_bad", 32'(bad_bit_ct_o), 32'd0);
        check("clean_word", 32'(word_ct_o), 32'd300);

        // periodic table
        do_reset();
        foreach (tbl[j]) begin
            step(1'b1, 2'd3, tbl[j].valid, tbl[j].sym);
            check("tbl_valid", 32'(valid_o), 32'(tbl[j].valid));
            check("tbl_sym", 32'(sym_o), 32'(tbl[j].exp_sym));
            check("tbl_err", 32'(err_o), 32'(tbl[j].exp_err));
        end
        check("per_inj", 32'(inj_ct_o), 32'd4);
        check("per_bad", 32'(bad_bit_ct_o), 32'd8);
        check("per_word", 32'(word_ct_o), 32'd64);

        // burst with gaps: three valid symbols corrupted, gap cycles quiet
        do_reset();
        find_burst(n_first);
        check("burst1_err", 32'(err_o), 32'd1);
        step(1'b1, 2'd2, 1'b0, W'($urandom_range(0, 3)));
        check("gap1_valid", 32'(valid_o), 32'd0);
        check("gap1_err", 32'(err_o), 32'd0);
        step(1'b1, 2'd2, 1'b1, W'($urandom_range(0, 3)));
        check("burst2_err", 32'(err_o), 32'd1);
        step(1'b1, 2'd2, 1'b0, W'($urandom_range(0, 3)));
        check("gap2_err", 32'(err_o), 32'd0);
        check("gap2_state", 32'(state_o), 32'(ST_BURST));
        step(1'b1, 2'd2, 1'b1, W'($urandom_range(0, 3)));
        check("burst3_err", 32'(err_o), 32'd1);
        check("burst_done_state", 32'(state_o), 32'(ST_IDLE));
        check("burst_inj", 32'(inj_ct_o), 32'd3);

        // en_i dropped mid-burst
        do_reset();
        find_burst(n_again);
        bad0 = m_bad;
        step(1'b0, 2'd2, 1'b1, W'($urandom_range(0, 3)));
        check("endrop_err", 32'(err_o), 32'd0);
        check("endrop_state", 32'(state_o), 32'(ST_IDLE));
        check("endrop_inj", 32'(inj_ct_o), 32'd1);
        check("endrop_bad", 32'(bad_bit_ct_o), 32'(bad0));

        // mode_i changed mid-burst
        do_reset();
        find_burst(n_again);
        step(1'b1, 2'd0, 1'b1, W'($urandom_range(0, 3)));
        check("modechg_err", 32'(err_o), 32'd0);
        check("modechg_state", 32'(state_o), 32'(ST_IDLE));
        check("modechg_inj", 32'(inj_ct_o), 32'd1);
        for (int j = 0; j < 4; j++) step(1'b1, 2'd2, 1'b1, W'($urandom_range(0, 3)));

        // asynchronous reset mid-burst, then the sequence restarts from the seed
        do_reset();
        find_burst(n_again);
        valid_i = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_valid_o", 32'(valid_o), 32'd0);
        check("arst_sym_o", 32'(sym_o), 32'd0);
        check("arst_err_o", 32'(err_o), 32'd0);
        check("arst_inj", 32'(inj_ct_o), 32'd0);
        check("arst_word", 32'(word_ct_o), 32'd0);
        check("arst_state", 32'(state_o), 32'(ST_IDLE));
        check("arst_lfsr", 32'(lfsr_o), 32'hACE1);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        find_burst(n_again);
        check("arst_repeat_pos", 32'(n_again), 32'(n_first));

        // random mode across the injection window
        do_reset();
        for (int j = 0; j < 1000; j++) begin
            step(1'b1, 2'd1, 1'b1, W'($urandom_range(0, 3)));
            if (j >= WIN) check("win_err", 32'(err_o), 32'd0);
        end
        check("win_word", 32'(word_ct_o), 32'd1000);
        check("win_inj", 32'(inj_ct_o), 32'(m_inj));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
